// File: rtl/enc16to4_drain_pkg.sv
// Shared types and sizing for the 16-to-4 draining encoder.
// Optional build macro: ENC16_MSB_FIRST_EN (picks the drain order in ffs16).
package enc16_pkg;

    localparam int N_IN   = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/enc16to4_drain_if.sv
// Request/code stream bundle of enc16to4_drain, plus the FSM state for observation.
// Handshake: a transfer happens on a cycle where VALID and READY are both high;
// the producer holds data stable while VALID is high and READY is low.
interface enc16to4_drain_if;
    import enc16_pkg::*;

    logic              ENA;
    logic              ENB;
    logic              ENC;
    logic [N_IN-1:0]   IN;
    logic              IN_VALID;
    logic              IN_READY;
    logic [CODE_W-1:0] OUT;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              OUT_LAST;
    logic [CNT_W-1:0]  OUT_CNT;
    logic              ZERO_PULSE;
    state_t            DBG_STATE;

    modport slave (
        input  ENA, ENB, ENC, IN, IN_VALID, OUT_READY,
        output IN_READY, OUT, OUT_VALID, OUT_LAST, OUT_CNT, ZERO_PULSE, DBG_STATE
    );

    modport master (
        output ENA, ENB, ENC, IN, IN_VALID, OUT_READY,
        input  IN_READY, OUT, OUT_VALID, OUT_LAST, OUT_CNT, ZERO_PULSE, DBG_STATE
    );

endinterface

// File: rtl/enc16to4_drain_ffs16.sv
// Combinational find-first-set over 16 bits: lowest set bit by default,
// highest set bit when ENC16_MSB_FIRST_EN is defined.
module ffs16
    import enc16_pkg::*;
(
    input  logic [N_IN-1:0]   vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
`ifdef ENC16_MSB_FIRST_EN
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < N_IN; i++) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
        end
`else
        // Descending scan: the last hit is the lowest set bit.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
        end
`endif
    end

endmodule

// File: rtl/enc16to4_drain.sv
// Sequential 16-to-4 encoder: accepts a request word and emits one code per set bit.
// Enabled when ENA & ENB & ~ENC; ENC16_MSB_FIRST_EN flips the drain order.
module enc16to4_drain
    import enc16_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    enc16to4_drain_if.slave  bus
);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zero_q, zero_d;

    logic              en;
    logic [CODE_W-1:0] ffs_idx;
    logic              ffs_any;
    logic              one_left;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              pop;

    ffs16 u_ffs (
        .vec_i (pending_q),
        .idx_o (ffs_idx),
        .any_o (ffs_any)
    );

    assign en       = bus.ENA & bus.ENB & ~bus.ENC;
    assign one_left = ffs_any && ((pending_q & (pending_q - N_IN'(1))) == '0);

    // Handshake outputs are forced low while reset is held.
    assign in_ready  = (state_q == IDLE)  & en & ~RST;
    assign out_valid = (state_q == DRAIN) & en & ~RST;
    assign accept    = bus.IN_VALID & in_ready;
    assign pop       = out_valid & bus.OUT_READY;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        zero_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.IN == '0) begin
                        zero_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        pending_d = bus.IN;
                        cnt_d     = popcount(bus.IN);
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    pending_d = pending_q & ~(N_IN'(1) << ffs_idx);
                    if (one_left) begin
                        pending_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_VALID  = out_valid;
    assign bus.OUT        = out_valid ? ffs_idx : '0;
    assign bus.OUT_LAST   = out_valid & one_left;
    assign bus.OUT_CNT    = cnt_q;
    assign bus.ZERO_PULSE = zero_q;
    assign bus.DBG_STATE  = state_q;

endmodule

// File: doc/enc16to4_drain.md
Name: enc16to4_drain

Overview:
- Sequential 16-to-4 encoder; the inverse of the Deco4to16 one-hot decoder.
- Accepts a 16-bit request word and emits one 4-bit code per set bit, LSB-first, over a valid/ready stream.
- Uses the same enable gating as Deco4to16: active only when ENA & ENB & ~ENC.
- Sits between request collectors and any consumer of Deco4to16-style codes; OUT can drive Deco4to16.IN directly.

Parameters:
- N_IN, 16, request vector width; fixed at 16 for this release.
- CODE_W, 4, code width; must equal log2(N_IN).
- CNT_W, 5, popcount width; must equal CODE_W+1.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- ENA  input  1  enable, active high.
- ENB  input  1  enable, active high.
- ENC  input  1  enable, active low (block enabled when ENA & ENB & ~ENC).
- IN  input  16  request word.
- IN_VALID  input  1  IN is valid.
- IN_READY  output  1  block can accept IN.
- OUT  output  4  encoded index of the current bit.
- OUT_VALID  output  1  OUT is valid.
- OUT_READY  input  1  consumer accepts OUT.
- OUT_LAST  output  1  OUT is the final code of the current word.
- OUT_CNT  output  5  popcount of the word being drained (0..16).
- ZERO_PULSE  output  1  one-cycle pulse: an all-zero word was accepted.

Behaviour:
- en = ENA & ENB & ~ENC, combinational.
- Reset: state IDLE, pending=0, OUT=0, OUT_VALID=0, OUT_LAST=0, OUT_CNT=0, ZERO_PULSE=0, IN_READY=0 during the reset cycle.
- Reset mid-drain discards the pending word; no further codes are emitted.
- States: IDLE, DRAIN.
- IDLE:
  - IN_READY = en.
  - Accept on IN_VALID & IN_READY.
  - IN==0: ZERO_PULSE=1 next cycle, OUT_CNT<=0, stay IDLE.
  - IN!=0: pending<=IN, OUT_CNT<=popcount(IN), go to DRAIN.
- DRAIN:
  - IN_READY=0.
  - OUT_VALID = en.
  - OUT = index of lowest set bit of pending.
  - OUT_LAST = (pending has exactly one bit set).
- Pop: on OUT_VALID & OUT_READY, clear that bit in pending. If OUT_LAST, go to IDLE; pending becomes 0.
- Latency: first OUT_VALID is 1 cycle after acceptance. A word with k set bits needs at least k cycles in DRAIN. The next word can be accepted no earlier than the cycle after the last pop, so there is one bubble between words.
- Enable drop during DRAIN: OUT_VALID=0, no pop, pending/state/OUT_CNT held. Resumes exactly where it stopped when en returns.
- OUT_READY low: OUT, OUT_LAST, pending held stable while OUT_VALID=1.
- When OUT_VALID=0, OUT and OUT_LAST drive 0.
- OUT_CNT: holds the last accepted word's popcount until the next acceptance; it is not decremented by pops.
- IN_VALID in DRAIN is ignored; the source must hold it.
- IN is sampled only at acceptance.

Optional Feature:
- Macro: ENC16_MSB_FIRST_EN.
- Defined: DRAIN emits the highest set bit first. OUT_LAST still marks the single remaining bit.
- Undefined (default): LSB-first, as described above.
- Ports and latency are identical in both builds.

Decomposition:
- Package enc16_pkg holds:
  - the state enum (IDLE, DRAIN);
  - localparams N_IN=16, CODE_W=4, CNT_W=5;
  - a popcount function.
- One sub-module, ffs16, is natural:
  - combinational find-first-set, 16-bit in, 4-bit index plus "any" out;
  - direction selected by ENC16_MSB_FIRST_EN;
  - the FSM/register logic lives in enc16to4_drain.

Test Plan:
- Reset then enable (ENA=1, ENB=1, ENC=0); IN=16'h0001 with IN_VALID, OUT_READY=1 -> next cycle OUT=0, OUT_VALID=1, OUT_LAST=1, OUT_CNT=1; IDLE after pop.
- IN=16'h8421, OUT_READY=1 -> codes 0,5,10,15 on 4 consecutive cycles, OUT_LAST only on 15, OUT_CNT=4. With ENC16_MSB_FIRST_EN the order is 15,10,5,0.
- IN=16'hFFFF, OUT_READY toggled 1/0 each cycle -> 16 codes 0..15, each held stable while not ready, OUT_CNT=16, 31 cycles in DRAIN.
- IN=16'h0000 accepted -> ZERO_PULSE high for exactly 1 cycle, OUT_VALID stays 0, IN_READY stays 1.
- IN=16'h0050, ENC=1 after the first pop -> OUT_VALID=0 and code 6 held. ENC=0 again -> OUT=6, OUT_LAST=1.
- RST asserted mid-drain of 16'h00F0 -> next cycle OUT_VALID=0, IN_READY=1 (enabled). A new IN=16'h0002 then yields OUT=1. Loop-back check: feed OUT into Deco4to16, and the OR of decoded outputs over the drain equals the original IN.
